// File: rtl/mano_ctrl_pkg.sv
// mano_ctrl_pkg: shared encodings for the Mano basic-computer control unit.
// Holds the bus-source codes, AC/E operation encodings, opcode indices
// and the IR bit positions used by the register-reference and I/O
// micro-operations.
package mano_ctrl_pkg;

  // Common-bus source select
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // AC operation encoding
  typedef enum logic [3:0] {
    AC_HOLD = 4'd0,
    AC_AND  = 4'd1,
    AC_ADD  = 4'd2,
    AC_LDDR = 4'd3,
    AC_INPR = 4'd4,
    AC_CMA  = 4'd5,
    AC_CIR  = 4'd6,
    AC_CIL  = 4'd7,
    AC_CLR  = 4'd8,
    AC_INC  = 4'd9
  } ac_op_e;

  // E flip-flop operation encoding
  typedef enum logic [1:0] {
    E_HOLD  = 2'd0,
    E_CLEAR = 2'd1,
    E_COMP  = 2'd2
  } e_op_e;

  // Run/halt state (the S flip-flop, stored inverted)
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Opcode indices into the one-hot D vector
  localparam int unsigned D_AND = 0;
  localparam int unsigned D_ADD = 1;
  localparam int unsigned D_LDA = 2;
  localparam int unsigned D_STA = 3;
  localparam int unsigned D_BUN = 4;
  localparam int unsigned D_BSA = 5;
  localparam int unsigned D_ISZ = 6;
  localparam int unsigned D_IO  = 7;

  // Register-reference micro-op bit positions in IR
  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  // I/O micro-op bit positions in IR
  localparam int unsigned IO_INP = 11;
  localparam int unsigned IO_OUT = 10;
  localparam int unsigned IO_SKI = 9;
  localparam int unsigned IO_SKO = 8;
  localparam int unsigned IO_ION = 7;
  localparam int unsigned IO_IOF = 6;

  // 3-to-8 opcode decoder producing the one-hot D vector
  function automatic logic [7:0] decode_opcode(input logic [2:0] op);
    logic [7:0] oh;
    oh     = 8'd0;
    oh[op] = 1'b1;
    return oh;
  endfunction

  // AC operation for a register-reference word; the lowest set
  // AC-affecting bit wins when several are set
  function automatic logic [3:0] rr_ac_op(input logic cla, input logic cma,
                                          input logic cir, input logic cil,
                                          input logic inc);
    logic [3:0] op;
    if (inc) begin
      op = AC_INC;
    end else if (cil) begin
      op = AC_CIL;
    end else if (cir) begin
      op = AC_CIR;
    end else if (cma) begin
      op = AC_CMA;
    end else if (cla) begin
      op = AC_CLR;
    end else begin
      op = AC_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/mano_sc_timer.sv
// mano_sc_timer: 3-bit sequence counter with increment, clear and hold,
// plus a one-hot decode of the current timing step T0..T7.
module mano_sc_timer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       inc,
  input  logic       clr,
  output logic [2:0] t,
  output logic [7:0] t_dec
);

  logic [2:0] t_r;

  // Sequence count: clear wins over increment, otherwise hold
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      t_r <= 3'd0;
    end else if (clr) begin
      t_r <= 3'd0;
    end else if (inc) begin
      t_r <= t_r + 3'd1;
    end else begin
      t_r <= t_r;
    end
  end

  // One-hot timing-step decode
  always_comb begin
    t_dec      = 8'd0;
    t_dec[t_r] = 1'b1;
  end

  assign t = t_r;

endmodule

// File: rtl/mano_control_unit.sv
// mano_control_unit: hardwired control unit of the Mano basic computer.
// Owns the sequence counter, the latched one-hot opcode D and the
// indirect bit I, and decodes every datapath strobe for fetch, indirect
// and execute. Defining MANO_INTERRUPT_EN adds the IEN/R flip-flops and
// the interrupt cycle that replaces fetch while R is set.
module mano_control_unit
  import mano_ctrl_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] IN_IR,
  input  logic          AC_MSB,
  input  logic          AC_ZERO,
  input  logic          DR_ZERO,
  input  logic          E_IN,
  input  logic          FGI,
  input  logic          FGO,
  input  logic          START,
  output logic [2:0]    BUS_SEL,
  output logic          AR_LD,
  output logic          AR_INC,
  output logic          AR_CLR,
  output logic          PC_LD,
  output logic          PC_INC,
  output logic          PC_CLR,
  output logic          DR_LD,
  output logic          DR_INC,
  output logic          IR_LD,
  output logic          TR_LD,
  output logic          OUTR_LD,
  output logic [3:0]    AC_OP,
  output logic [1:0]    E_OP,
  output logic          MEM_RD,
  output logic          MEM_WR,
  output logic          FGI_CLR,
  output logic          FGO_CLR,
  output logic [2:0]    T,
  output logic          HALTED
);

  logic [2:0]    t_s;
  logic [7:0]    td_s;
  logic [7:0]    d_r;
  logic          i_r;
  run_state_e    state_r;
  logic          ien_r;
  logic          r_r;
  logic          active_s;
  logic          sc_clr_s;
  logic          sc_inc_s;
  logic          hlt_s;
  logic          ien_set_s;
  logic          ien_clr_s;
  logic          r_clr_s;
  logic [AW-1:0] b_s;

  // Micro-op field of the instruction word
  assign b_s = IN_IR[AW-1:0];

  // Strobes are only live when out of reset and not halted
  assign active_s = RST_N & (state_r == ST_RUN);
  assign sc_inc_s = (state_r == ST_RUN);

  mano_sc_timer u_sc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (sc_inc_s),
    .clr   (sc_clr_s),
    .t     (t_s),
    .t_dec (td_s)
  );

  // Control-strobe decode for the current timing step
  always_comb begin
    BUS_SEL   = BUS_NONE;
    AR_LD     = 1'b0;
    AR_INC    = 1'b0;
    AR_CLR    = 1'b0;
    PC_LD     = 1'b0;
    PC_INC    = 1'b0;
    PC_CLR    = 1'b0;
    DR_LD     = 1'b0;
    DR_INC    = 1'b0;
    IR_LD     = 1'b0;
    TR_LD     = 1'b0;
    OUTR_LD   = 1'b0;
    AC_OP     = AC_HOLD;
    E_OP      = E_HOLD;
    MEM_RD    = 1'b0;
    MEM_WR    = 1'b0;
    FGI_CLR   = 1'b0;
    FGO_CLR   = 1'b0;
    sc_clr_s  = 1'b0;
    hlt_s     = 1'b0;
    ien_set_s = 1'b0;
    ien_clr_s = 1'b0;
    r_clr_s   = 1'b0;
    if (!active_s) begin
      sc_clr_s = 1'b0;
    end else begin
      case (1'b1)
        td_s[0]: begin
          if (r_r) begin
            AR_CLR  = 1'b1;
            BUS_SEL = BUS_TR;
            TR_LD   = 1'b1;
          end else begin
            BUS_SEL = BUS_PC;
            AR_LD   = 1'b1;
          end
        end
        td_s[1]: begin
          if (r_r) begin
            BUS_SEL = BUS_TR;
            MEM_WR  = 1'b1;
            PC_CLR  = 1'b1;
          end else begin
            BUS_SEL = BUS_MEM;
            MEM_RD  = 1'b1;
            IR_LD   = 1'b1;
            PC_INC  = 1'b1;
          end
        end
        td_s[2]: begin
          if (r_r) begin
            PC_INC    = 1'b1;
            ien_clr_s = 1'b1;
            r_clr_s   = 1'b1;
            sc_clr_s  = 1'b1;
          end else begin
            BUS_SEL = BUS_IR;
            AR_LD   = 1'b1;
          end
        end
        td_s[3]: begin
          if (d_r[D_IO] && i_r) begin
            AC_OP     = b_s[IO_INP] ? AC_INPR : AC_HOLD;
            FGI_CLR   = b_s[IO_INP];
            BUS_SEL   = b_s[IO_OUT] ? BUS_AC : BUS_NONE;
            OUTR_LD   = b_s[IO_OUT];
            FGO_CLR   = b_s[IO_OUT];
            PC_INC    = (b_s[IO_SKI] & FGI) | (b_s[IO_SKO] & FGO);
            ien_set_s = b_s[IO_ION];
            ien_clr_s = b_s[IO_IOF];
            sc_clr_s  = 1'b1;
          end else if (d_r[D_IO]) begin
            AC_OP    = rr_ac_op(b_s[RR_CLA], b_s[RR_CMA], b_s[RR_CIR],
                                b_s[RR_CIL], b_s[RR_INC]);
            E_OP     = b_s[RR_CME] ? E_COMP : (b_s[RR_CLE] ? E_CLEAR : E_HOLD);
            PC_INC   = (b_s[RR_SPA] & ~AC_MSB) | (b_s[RR_SNA] & AC_MSB) |
                       (b_s[RR_SZA] & AC_ZERO) | (b_s[RR_SZE] & ~E_IN);
            hlt_s    = b_s[RR_HLT];
            sc_clr_s = 1'b1;
          end else if (i_r) begin
            BUS_SEL = BUS_MEM;
            MEM_RD  = 1'b1;
            AR_LD   = 1'b1;
          end else begin
            sc_clr_s = 1'b0;
          end
        end
        td_s[4]: begin
          if (d_r[D_AND] || d_r[D_ADD] || d_r[D_LDA] || d_r[D_ISZ]) begin
            BUS_SEL = BUS_MEM;
            MEM_RD  = 1'b1;
            DR_LD   = 1'b1;
          end else if (d_r[D_STA]) begin
            BUS_SEL  = BUS_AC;
            MEM_WR   = 1'b1;
            sc_clr_s = 1'b1;
          end else if (d_r[D_BUN]) begin
            BUS_SEL  = BUS_AR;
            PC_LD    = 1'b1;
            sc_clr_s = 1'b1;
          end else if (d_r[D_BSA]) begin
            BUS_SEL = BUS_PC;
            MEM_WR  = 1'b1;
            AR_INC  = 1'b1;
          end else begin
            sc_clr_s = 1'b0;
          end
        end
        td_s[5]: begin
          if (d_r[D_AND]) begin
            AC_OP    = AC_AND;
            sc_clr_s = 1'b1;
          end else if (d_r[D_ADD]) begin
            AC_OP    = AC_ADD;
            sc_clr_s = 1'b1;
          end else if (d_r[D_LDA]) begin
            AC_OP    = AC_LDDR;
            sc_clr_s = 1'b1;
          end else if (d_r[D_BSA]) begin
            BUS_SEL  = BUS_AR;
            PC_LD    = 1'b1;
            sc_clr_s = 1'b1;
          end else if (d_r[D_ISZ]) begin
            DR_INC = 1'b1;
          end else begin
            sc_clr_s = 1'b0;
          end
        end
        td_s[6]: begin
          if (d_r[D_ISZ]) begin
            BUS_SEL  = BUS_DR;
            MEM_WR   = 1'b1;
            PC_INC   = DR_ZERO;
            sc_clr_s = 1'b1;
          end else begin
            sc_clr_s = 1'b0;
          end
        end
        default: begin
          // T7 is never reached by a legal instruction; recover to T0
          sc_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Opcode/indirect latch at T2 and the run/halt state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d_r     <= 8'd0;
      i_r     <= 1'b0;
      state_r <= ST_RUN;
    end else begin
      if (td_s[2] && !r_r && (state_r == ST_RUN)) begin
        d_r <= decode_opcode(IN_IR[DW-2:DW-4]);
        i_r <= IN_IR[DW-1];
      end
      case (state_r)
        ST_RUN:  if (hlt_s) state_r <= ST_HALT;
        ST_HALT: if (START) state_r <= ST_RUN;
        default: state_r <= ST_HALT;
      endcase
    end
  end

`ifdef MANO_INTERRUPT_EN
  logic r_set_s;

  assign r_set_s = ~td_s[0] & ~td_s[1] & ~td_s[2] & ien_r & (FGI | FGO) &
                   (state_r == ST_RUN);

  // Interrupt enable and pending-interrupt request flip-flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ien_r <= 1'b0;
      r_r   <= 1'b0;
    end else begin
      if (ien_clr_s) begin
        ien_r <= 1'b0;
      end else if (ien_set_s) begin
        ien_r <= 1'b1;
      end
      if (r_clr_s) begin
        r_r <= 1'b0;
      end else if (r_set_s) begin
        r_r <= 1'b1;
      end
    end
  end
`else
  logic int_unused_s;

  assign ien_r        = 1'b0;
  assign r_r          = 1'b0;
  assign int_unused_s = ^{ien_set_s, ien_clr_s, r_clr_s, ien_r};
`endif

  assign T      = t_s;
  assign HALTED = (state_r == ST_HALT);

endmodule

// File: tb/tb_mano_control_unit.sv
// tb_mano_control_unit: self-checking bench for mano_control_unit.
// Expected strobes come from an instruction-level microprogram model
// built per instruction from the Mano instruction set tables.
module tb_mano_control_unit;

  typedef struct packed {
    logic [2:0] bus;
    logic       ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr;
    logic       dr_ld, dr_inc, ir_ld, tr_ld, outr_ld;
    logic [3:0] ac_op;
    logic [1:0] e_op;
    logic       mem_rd, mem_wr, fgi_clr, fgo_clr;
  } ctl_t;

  typedef struct {
    ctl_t       c;
    logic [2:0] t;
  } step_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] IN_IR;
  logic        AC_MSB, AC_ZERO, DR_ZERO, E_IN, FGI, FGO, START;
  logic [2:0]  BUS_SEL, T;
  logic        AR_LD, AR_INC, AR_CLR, PC_LD, PC_INC, PC_CLR;
  logic        DR_LD, DR_INC, IR_LD, TR_LD, OUTR_LD;
  logic [3:0]  AC_OP;
  logic [1:0]  E_OP;
  logic        MEM_RD, MEM_WR, FGI_CLR, FGO_CLR, HALTED;

  ctl_t  obs;
  step_t exp_q[$];
  bit    ien_m;
  int    n_checks;
  int    n_fail;

  mano_control_unit #(.AW(12), .DW(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_IR(IN_IR), .AC_MSB(AC_MSB),
    .AC_ZERO(AC_ZERO), .DR_ZERO(DR_ZERO), .E_IN(E_IN), .FGI(FGI),
    .FGO(FGO), .START(START), .BUS_SEL(BUS_SEL), .AR_LD(AR_LD),
    .AR_INC(AR_INC), .AR_CLR(AR_CLR), .PC_LD(PC_LD), .PC_INC(PC_INC),
    .PC_CLR(PC_CLR), .DR_LD(DR_LD), .DR_INC(DR_INC), .IR_LD(IR_LD),
    .TR_LD(TR_LD), .OUTR_LD(OUTR_LD), .AC_OP(AC_OP), .E_OP(E_OP),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .FGI_CLR(FGI_CLR),
    .FGO_CLR(FGO_CLR), .T(T), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  assign obs = {BUS_SEL, AR_LD, AR_INC, AR_CLR, PC_LD, PC_INC, PC_CLR,
                DR_LD, DR_INC, IR_LD, TR_LD, OUTR_LD, AC_OP, E_OP,
                MEM_RD, MEM_WR, FGI_CLR, FGO_CLR};

  // AC code selected by a register-reference bit (0 = bit has no AC effect)
  function automatic logic [3:0] ac_of_bit(input int b);
    case (b)
      5:       return 4'd9;
      6:       return 4'd7;
      7:       return 4'd6;
      9:       return 4'd5;
      11:      return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic push_step(input ctl_t c, input int t);
    step_t s;
    s.c = c;
    s.t = 3'(t);
    exp_q.push_back(s);
  endtask

  // Build the expected cycle-by-cycle strobes of one instruction
  task automatic build_prog(input logic [15:0] ir, input logic [5:0] fl);
    ctl_t       c;
    logic [2:0] op;
    bit         ind, irq;
    logic       msb, az, dz, e, fgi, fgo;
    {msb, az, dz, e, fgi, fgo} = fl;
    op  = ir[14:12];
    ind = ir[15];
    irq = 1'b0;
    exp_q.delete();
    c = '0; c.bus = 3'd2; c.ar_ld = 1'b1; push_step(c, 0);
    c = '0; c.bus = 3'd7; c.mem_rd = 1'b1; c.ir_ld = 1'b1; c.pc_inc = 1'b1; push_step(c, 1);
    c = '0; c.bus = 3'd5; c.ar_ld = 1'b1; push_step(c, 2);
    c = '0;
`ifdef MANO_INTERRUPT_EN
    irq = ien_m && (fgi || fgo);
`endif
    if (op == 3'd7 && !ind) begin
      for (int b = 5; b <= 11; b++) begin
        if (ir[b] && ac_of_bit(b) != 4'd0) begin
          c.ac_op = ac_of_bit(b);
          break;
        end
      end
      c.e_op   = ir[8] ? 2'd2 : (ir[10] ? 2'd1 : 2'd0);
      c.pc_inc = (ir[4] && !msb) || (ir[3] && msb) || (ir[2] && az) || (ir[1] && !e);
      push_step(c, 3);
    end else if (op == 3'd7) begin
      c.ac_op   = ir[11] ? 4'd4 : 4'd0;
      c.fgi_clr = ir[11];
      c.bus     = ir[10] ? 3'd4 : 3'd0;
      c.outr_ld = ir[10];
      c.fgo_clr = ir[10];
      c.pc_inc  = (ir[9] && fgi) || (ir[8] && fgo);
      push_step(c, 3);
`ifdef MANO_INTERRUPT_EN
      if (ir[7]) ien_m = 1'b1;
      if (ir[6]) ien_m = 1'b0;
`endif
    end else begin
      if (ind) begin
        c.bus = 3'd7; c.mem_rd = 1'b1; c.ar_ld = 1'b1;
      end
      push_step(c, 3);
      c = '0;
      case (op)
        3'd0, 3'd1, 3'd2: begin
          c.bus = 3'd7; c.mem_rd = 1'b1; c.dr_ld = 1'b1; push_step(c, 4);
          c = '0; c.ac_op = {1'b0, op} + 4'd1; push_step(c, 5);
        end
        3'd3: begin
          c.bus = 3'd4; c.mem_wr = 1'b1; push_step(c, 4);
        end
        3'd4: begin
          c.bus = 3'd1; c.pc_ld = 1'b1; push_step(c, 4);
        end
        3'd5: begin
          c.bus = 3'd2; c.mem_wr = 1'b1; c.ar_inc = 1'b1; push_step(c, 4);
          c = '0; c.bus = 3'd1; c.pc_ld = 1'b1; push_step(c, 5);
        end
        default: begin
          c.bus = 3'd7; c.mem_rd = 1'b1; c.dr_ld = 1'b1; push_step(c, 4);
          c = '0; c.dr_inc = 1'b1; push_step(c, 5);
          c = '0; c.bus = 3'd3; c.mem_wr = 1'b1; c.pc_inc = dz; push_step(c, 6);
        end
      endcase
    end
    if (irq) begin
      c = '0; c.ar_clr = 1'b1; c.bus = 3'd6; c.tr_ld = 1'b1; push_step(c, 0);
      c = '0; c.bus = 3'd6; c.mem_wr = 1'b1; c.pc_clr = 1'b1; push_step(c, 1);
      c = '0; c.pc_inc = 1'b1; push_step(c, 2);
      ien_m = 1'b0;
    end
  endtask

  // Run one instruction from T0 and compare every cycle against the model
  task automatic run_instr(input string name, input logic [15:0] ir,
                           input logic [5:0] fl, input bit rnd_start);
    IN_IR = ir;
    {AC_MSB, AC_ZERO, DR_ZERO, E_IN, FGI, FGO} = fl;
    build_prog(ir, fl);
    for (int k = 0; k < exp_q.size(); k++) begin
      START = rnd_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge CLK);
      n_checks++;
      if (obs !== exp_q[k].c || T !== exp_q[k].t || HALTED !== 1'b0) begin
        n_fail++;
        $display("FAIL %s ir=%h step %0d: got ctl=%h T=%0d HALTED=%b, expected ctl=%h T=%0d HALTED=0",
                 name, ir, k, obs, T, HALTED, exp_q[k].c, exp_q[k].t);
      end
      @(posedge CLK);
      #1;
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    IN_IR = 16'h7FFF;
    {AC_MSB, AC_ZERO, DR_ZERO, E_IN, FGI, FGO, START} = 7'd0;
    ien_m = 1'b0;
    #2 RST_N = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (obs !== ctl_t'(0) || T !== 3'd0 || HALTED !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got ctl=%h T=%0d HALTED=%b, expected ctl=0 T=0 HALTED=0", obs, T, HALTED);
    end
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic test_mem_ref();
    run_instr("lda_direct", 16'h2005, 6'd0, 1'b0);
    run_instr("lda_indirect", 16'hA010, 6'd0, 1'b0);
    run_instr("isz_dr_zero", 16'h6020, 6'b001000, 1'b0);
    run_instr("isz_dr_nonzero", 16'h6020, 6'b000000, 1'b0);
    run_instr("spa_pos", 16'h7010, 6'b000000, 1'b0);
    run_instr("spa_neg", 16'h7010, 6'b100000, 1'b0);
  endtask

  task automatic test_halt();
    run_instr("hlt", 16'h7001, 6'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_checks++;
      if (obs !== ctl_t'(0) || T !== 3'd0 || HALTED !== 1'b1) begin
        n_fail++;
        $display("FAIL halted_idle %0d: got ctl=%h T=%0d HALTED=%b, expected ctl=0 T=0 HALTED=1", i, obs, T, HALTED);
      end
      @(posedge CLK);
      #1;
    end
    START = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (obs !== ctl_t'(0) || HALTED !== 1'b1) begin
      n_fail++;
      $display("FAIL start_cycle: got ctl=%h HALTED=%b, expected ctl=0 HALTED=1", obs, HALTED);
    end
    @(posedge CLK);
    #1 START = 1'b0;
    run_instr("after_start", 16'h7800, 6'd0, 1'b0);
  endtask

  task automatic test_interrupt();
    run_instr("ion", 16'hF080, 6'b000010, 1'b0);
    run_instr("cla_flag", 16'h7800, 6'b000010, 1'b0);
    run_instr("cla_after", 16'h7800, 6'b000011, 1'b0);
  endtask

  task automatic test_reset_mid();
    IN_IR = 16'h3123;
    {AC_MSB, AC_ZERO, DR_ZERO, E_IN, FGI, FGO} = 6'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    n_checks++;
    if (MEM_WR !== 1'b1 || BUS_SEL !== 3'd4 || T !== 3'd4) begin
      n_fail++;
      $display("FAIL sta_t4: got MEM_WR=%b BUS_SEL=%0d T=%0d, expected 1 4 4", MEM_WR, BUS_SEL, T);
    end
    #1 RST_N = 1'b0;
    #1;
    n_checks++;
    if (obs !== ctl_t'(0) || T !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got ctl=%h T=%0d, expected ctl=0 T=0", obs, T);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (MEM_WR !== 1'b0 || obs !== ctl_t'(0)) begin
      n_fail++;
      $display("FAIL reset_hold: got ctl=%h, expected 0", obs);
    end
    RST_N = 1'b1;
    ien_m = 1'b0;
    run_instr("after_reset", 16'h7400, 6'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        ind;
    logic [11:0] low;
    for (int i = 0; i < 150; i++) begin
      op  = 3'($urandom_range(0, 7));
      ind = 1'($urandom_range(0, 1));
      low = 12'($urandom);
      if (op == 3'd7 && !ind) low[0] = 1'b0;
      run_instr("random", {ind, op, low}, 6'($urandom), 1'b1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mem_ref();
    test_halt();
    test_interrupt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
